// File: rtl/mul8_seq_if.sv
// Handshake bundle for the sequential 8x8 multiplier.
//   in_valid/in_ready  : operand pair handshake (a, b)
//   out_valid/out_ready: product handshake (product)
//   busy               : multiplier is in RUN or DONE
// slave modport is the multiplier side, master the requester/consumer side.
interface mul8_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/mul8_seq.sv
// Sequential 8x8 unsigned shift-add multiplier.
//   adder8  : 8-bit ripple-carry adder, one full-adder cell per bit.
//   mul8_seq: accepts (a, b), runs 8 shift-add iterations through a single
//             adder8 instance, then presents the 16-bit product until taken.
// Ports (mul8_seq):
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - mul8_seq_if.slave (in/out handshakes, operands, product, busy)

module adder8 (
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       ci,
  output logic [7:0] sum,
  output logic       co
);
  logic [8:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign sum[i]  = x[i] ^ y[i] ^ c[i];
    assign c[i+1]  = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign co = c[8];
endmodule

module mul8_seq (
  input  logic       clk,
  input  logic       rst_n,
  mul8_seq_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  mcand;
  logic [7:0]  hi;
  logic [7:0]  lo;
  logic [2:0]  cnt;
  logic [15:0] product_q;

  logic [7:0]  addend;
  logic [7:0]  sum;
  logic        c;
  logic [15:0] shifted;
  logic        accept;

  // Partial product for this iteration: add the multiplicand only when the
  // current multiplier bit (lo[0]) is set.
  assign addend = lo[0] ? mcand : 8'd0;

  adder8 u_add (
    .x   (hi),
    .y   (addend),
    .ci  (1'b0),
    .sum (sum),
    .co  (c)
  );

  // 17-bit {c,sum,lo} shifted right by one; the carry-out becomes hi[7] so
  // 255*255 does not lose its top bit.
  assign shifted = {c, sum, lo[7:1]};

  assign accept = (state == IDLE) && bus.in_valid;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and handshake outputs
  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = RUN;
      end
      RUN: begin
        bus.busy = 1'b1;
        if (cnt == 3'd7) state_nxt = DONE;
      end
      DONE: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath. Operands are captured once on accept, so a/b/in_valid activity
  // during RUN/DONE cannot disturb the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand     <= 8'd0;
      hi        <= 8'd0;
      lo        <= 8'd0;
      cnt       <= 3'd0;
      product_q <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mcand <= bus.a;
            lo    <= bus.b;
            hi    <= 8'd0;
            cnt   <= 3'd0;
          end
        end
        RUN: begin
          {hi, lo} <= shifted;
          cnt      <= cnt + 3'd1;
          // Capture the final value on the last iteration; the register
          // then holds it through DONE and after, until the next result.
          if (cnt == 3'd7) product_q <= shifted;
        end
        default: ;
      endcase
    end
  end

  assign bus.product = product_q;
endmodule

// File: tb/tb_mul8_seq.sv
// Self-checking bench for mul8_seq: directed vectors plus a stalled random
// sweep, checked through an expected-product queue drained by a monitor.
module tb_mul8_seq;
  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [15:0] exp_q[$];

  mul8_seq_if bus ();

  mul8_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present an operand pair, wait for acceptance, queue its expected product.
  // Returns just after the accepting edge with a/b scrambled.
  task automatic issue(input logic [7:0] x, input logic [7:0] y,
                       input logic [15:0] p, input bit push);
    bit ok;
    ok = 1'b0;
    bus.a = x;
    bus.b = y;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("accept_timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
    end else begin
      if (push) exp_q.push_back(p);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.a = 8'($urandom);
      bus.b = 8'($urandom);
    end
  endtask

  // Count edges after acceptance until out_valid shows; in_valid is waved
  // during RUN to show it is ignored.
  task automatic wait_out(output int k);
    k = 0;
    while (k < 30) begin
      @(posedge clk);
      #1;
      k++;
      bus.in_valid = (k < 5) ? 1'b1 : 1'b0;
      bus.a = 8'($urandom);
      bus.b = 8'($urandom);
      if (bus.out_valid) break;
    end
    bus.in_valid = 1'b0;
    if (!bus.out_valid) chk("out_valid_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: pops the queue on each product handshake and checks that a
  // stalled product stays put.
  initial begin : mon
    bit hold;
    logic [15:0] pp;
    logic [15:0] e;
    hold = 1'b0;
    pp = 16'd0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (hold) begin
          chk("hold_valid", 32'(bus.out_valid), 32'd1);
          chk("hold_product", 32'(bus.product), 32'(pp));
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) chk("unexpected_output", 32'd1, 32'd0);
          else begin
            e = exp_q.pop_front();
            chk("product", 32'(bus.product), 32'(e));
          end
        end
        hold = bus.out_valid && !bus.out_ready;
        pp   = bus.product;
      end else begin
        hold = 1'b0;
      end
    end
  end

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t vecs[8] = '{
    '{8'd35,  8'd62,  16'd2170},
    '{8'd255, 8'd255, 16'd65025},
    '{8'd190, 8'd104, 16'd19760},
    '{8'd0,   8'd200, 16'd0},
    '{8'd200, 8'd0,   16'd0},
    '{8'd1,   8'd1,   16'd1},
    '{8'd128, 8'd2,   16'd256},
    '{8'd15,  8'd17,  16'd255}
  };

  initial begin : drv
    int  k;
    bit  done;
    logic [7:0] x;
    logic [7:0] y;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = 8'd0;
    bus.b         = 8'd0;
    bus.out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    chk("rst_product",   32'(bus.product),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors, consumer always ready
    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].p, 1'b1);
      chk("busy_after_accept", 32'(bus.busy), 32'd1);
      chk("in_ready_in_run", 32'(bus.in_ready), 32'd0);
      wait_out(k);
      chk("latency", 32'(k), 32'd8);
      @(posedge clk);
      #1;
      chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
      chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
      chk("product_held", 32'(bus.product), 32'(vecs[i].p));
    end

    // Consumer stall: product must hold, no new accept
    bus.out_ready = 1'b0;
    issue(8'd10, 8'd160, 16'd1600, 1'b1);
    wait_out(k);
    chk("stall_latency", 32'(k), 32'd8);
    bus.in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("stall_product", 32'(bus.product), 32'd1600);
      chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_in_ready", 32'(bus.in_ready), 32'd1);
    chk("release_out_valid", 32'(bus.out_valid), 32'd0);

    // Reset in the middle of RUN aborts the operation
    issue(8'd255, 8'd255, 16'd65025, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_in_ready",  32'(bus.in_ready),  32'd1);
    chk("abort_busy",      32'(bus.busy),      32'd0);
    chk("abort_product",   32'(bus.product),   32'd0);
    bus.in_valid = 1'b1;
    bus.a = 8'd7;
    bus.b = 8'd9;
    repeat (2) @(posedge clk);
    #1;
    chk("no_accept_in_reset", 32'(bus.busy), 32'd0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("post_rst_busy", 32'(bus.busy), 32'd0);
    issue(8'd3, 8'd5, 16'd15, 1'b1);
    wait_out(k);
    chk("post_rst_latency", 32'(k), 32'd8);
    @(posedge clk);
    #1;

    // Random sweep with input gaps and consumer stalls
    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 600; n++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          x = 8'($urandom);
          y = 8'($urandom);
          issue(x, y, {8'd0, x} * {8'd0, y}, 1'b1);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join

    for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(posedge clk);
    @(negedge clk);
    chk("drain", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
